counter_tick_ctrl: RTL and testbench
====================================

# counter_tick_ctrl

Upstream control stage for the LED counter. It debounces two raw push-buttons (run/stop and direction), keeps the counter's run and direction state, and produces a one-cycle count-enable pulse (`tick`) every `DIV` clock cycles while running. The counter consumes `tick`, `run` and `dir` directly and advances only on cycles where `tick` is high.

## Interface
- `DIV`, default 100_000_000: prescaler period in clk cycles (1 Hz at 100 MHz); legal range ≥ 2.
- `DEB_CYCLES`, default 1_000_000: cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz); legal range ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_run`  in  1  raw, asynchronous, bouncing button, active-high; each press toggles `run`.
- `btn_dir`  in  1  raw, asynchronous, bouncing button, active-high; each press toggles `dir`.
- `tick`  out  1  registered count-enable pulse, one cycle wide.
- `run`  out  1  registered; 1 = counting, 0 = paused.
- `dir`  out  1  registered; 1 = count up, 0 = count down.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer (`s1`, `s2`). Reset values are 0.
- **Debouncer:** one per button, holding a `stable` level (reset 0) and a counter of width clog2(`DEB_CYCLES`)+1.
  - If `s2 == stable`, the counter clears to 0.
  - If `s2 != stable` and counter < `DEB_CYCLES`-1, the counter increments.
  - If `s2 != stable` and counter == `DEB_CYCLES`-1, `stable <= s2` and the counter clears.
  - Any mismatch run shorter than `DEB_CYCLES` cycles is discarded.
- **Press event:** fires when the debounced level goes 0→1. It is detected as `stable & ~stable_d`, where `stable_d` is the registered previous value. Release edges generate no event.
- **Control registers:**
  - A run event toggles `run`.
  - A dir event toggles `dir`.
  - Both events in the same cycle toggle both registers in that cycle.
  - A dir toggle does not affect the prescaler or `tick`.
- **Prescaler:** counter `pcnt` counts 0..`DIV`-1, width clog2(`DIV`).
  - `run` = 1 and `pcnt` == `DIV`-1: `pcnt <= 0` and `tick <= 1`.
  - `run` = 1 otherwise: `pcnt <= pcnt + 1` and `tick <= 0`.
  - `run` = 0: `pcnt` holds and `tick <= 0`. Pausing freezes the phase; it does not clear it.
- **Reset:**
  - Outputs: `tick` = 0, `run` = 0, `dir` = 1.
  - Internal state: `pcnt` = 0; all synchronizer, `stable`, `stable_d` and debounce-counter state = 0.
  - A reset asserted mid-press or mid-period discards everything.
  - A button still held when `rst` deasserts is seen as a fresh 0→1 change. It yields exactly one press after the full debounce latency.

## Timing
- **Button latency:** let edge 0 be the first rising edge that samples the new raw level.
  - `s2` changes after edge 1.
  - `stable` changes after edge `DEB_CYCLES`+1.
  - `run`/`dir` toggle after edge `DEB_CYCLES`+2, i.e. they are visible `DEB_CYCLES`+3 cycles after edge 0.
- **Tick latency and period:**
  - From `run` rising with `pcnt` = 0, `tick` is first high after the `DIV`-th rising edge at which `run` = 1.
  - Thereafter `tick` is high exactly 1 cycle in every `DIV`.
  - On resume from pause with `pcnt` = p, the next `tick` is high after `DIV`-p edges.
- **Pause boundary:** `run` falling in the same cycle that `pcnt` would wrap means no tick is issued, because the `run` value sampled at the edge governs.
- **Throughput limit:** back-to-back presses need each level, pressed and released, stable ≥ `DEB_CYCLES` cycles. This gives a maximum of one accepted press per 2·`DEB_CYCLES` cycles.

## Test plan
Parameters for all scenarios: `DIV`=4, `DEB_CYCLES`=3.
1. **Reset:** `rst`=1 for 2 cycles, buttons low, then 20 idle cycles -> `tick`=0, `run`=0, `dir`=1 throughout, no tick.
2. **Clean run press:** `btn_run`=1 for 10 cycles, then 0 -> `run` becomes 1 6 cycles after edge 0. `tick` pulses one cycle wide, first 4 cycles after `run` rises, then every 4 cycles.
3. **Bounce rejection:** `btn_run` alternates 1/0 every 2 cycles for 12 cycles, then stays 0 -> `run` unchanged, no tick. A clean 3-cycle-stable press afterwards -> exactly one toggle.
4. **Pause/resume:**
   - Press `btn_run` so `run` 1→0 while `pcnt`=2 -> `tick` stays 0 and `pcnt` holds 2.
   - Press again -> first `tick` after 2 edges with `run`=1, then period 4.
5. **Direction:**
   - `btn_dir` press -> `dir` 1→0, tick cadence unchanged.
   - Both buttons pressed on the same cycle -> `run` and `dir` toggle on the same edge.
6. **Reset mid-operation:**
   - `rst` pulsed while `run`=1 and `pcnt`=2 -> next cycle `tick`=0, `run`=0, `dir`=1, `pcnt`=0.
   - `btn_run` held high through reset release -> `run` becomes 1 exactly 6 cycles after the first post-reset sampling edge.

Source files
------------

// File: rtl/counter_tick_ctrl_if.sv
// Button inputs and run/dir/tick control outputs of the LED counter control stage.
// Latency: none, wires only.
// Backpressure: none; the counter samples tick/run/dir every cycle.
interface counter_tick_ctrl_if;
    logic btn_run;
    logic btn_dir;
    logic tick;
    logic run;
    logic dir;

    // Stimulus side: drives the raw buttons and observes the control outputs.
    modport master (
        output btn_run,
        output btn_dir,
        input  tick,
        input  run,
        input  dir
    );

    // Control block side.
    modport slave (
        input  btn_run,
        input  btn_dir,
        output tick,
        output run,
        output dir
    );
endinterface

// File: rtl/counter_tick_ctrl.sv
// Debounces run/dir buttons, holds run/dir state and emits a one-cycle tick every DIV cycles while running.
// Latency: button press to run/dir toggle DEB_CYCLES+3 cycles; first tick DIV cycles after run rises from phase 0.
// Backpressure: none; tick/run/dir are free-running registered outputs.
module counter_tick_ctrl #(
    parameter int DIV        = 100_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    counter_tick_ctrl_if.slave   if_ctrl
);

    localparam int DW = $clog2(DEB_CYCLES) + 1;
    localparam int PW = $clog2(DIV);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

    // Bit 0 carries the run button, bit 1 the dir button.
    logic [1:0]    w_btn;
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_stable;
    logic [1:0]    r_stable_d;
    logic [DW-1:0] r_dcnt [2];
    logic [1:0]    w_press;

    logic          r_run;
    logic          r_dir;
    logic          r_tick;
    logic [PW-1:0] r_pcnt;

    assign w_btn = {if_ctrl.btn_dir, if_ctrl.btn_run};

    // Only a debounced 0->1 level change counts as a press; releases are ignored.
    assign w_press = r_stable & ~r_stable_d;

    // Two-flop synchronizers for the raw buttons, plus the previous debounced level for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_stable_d <= '0;
        end else begin
            r_s1       <= w_btn;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
        end
    end

    // Debounce: accept a new level only after it has differed from the stable one for DEB_CYCLES cycles in a row.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stable <= '0;
            for (int i = 0; i < 2; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DEB_LAST) begin
                    r_stable[i] <= r_s2[i];
                    r_dcnt[i]   <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + DW'(1);
                end
            end
        end
    end

    // Run and direction toggle on their own press events; simultaneous presses toggle both.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run <= 1'b0;
            r_dir <= 1'b1;
        end else begin
            r_run <= r_run ^ w_press[0];
            r_dir <= r_dir ^ w_press[1];
        end
    end

    // Prescaler: the registered run value gates counting, so pausing freezes the phase rather than clearing it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else if (r_run) begin
            if (r_pcnt == PCNT_LAST) begin
                r_pcnt <= '0;
                r_tick <= 1'b1;
            end else begin
                r_pcnt <= r_pcnt + PW'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign if_ctrl.tick = r_tick;
    assign if_ctrl.run  = r_run;
    assign if_ctrl.dir  = r_dir;

endmodule

// File: tb/tb_counter_tick_ctrl.sv
// Directed bench for counter_tick_ctrl with DIV=4, DEB_CYCLES=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected edge counts are worked out by hand from the button/tick timing.
module tb_counter_tick_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    counter_tick_ctrl_if u_if ();

    counter_tick_ctrl #(
        .DIV        (4),
        .DEB_CYCLES (3)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .if_ctrl (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until tick is seen high; returns -1 if it does not appear within max_edges.
    task automatic edges_to_tick(input int max_edges, output int n);
        n = 0;
        while (1) begin
            step(1);
            n++;
            if (u_if.tick === 1'b1) break;
            if (n >= max_edges) begin
                n = -1;
                break;
            end
        end
    endtask

    initial begin
        int  n;
        bit  saw_tick;
        bit  saw_run;
        bit  saw_dir0;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        u_if.btn_run = 1'b0;
        u_if.btn_dir = 1'b0;

        // Reset and idle
        step(2);
        check("rst_tick", u_if.tick, 0);
        check("rst_run",  u_if.run,  0);
        check("rst_dir",  u_if.dir,  1);
        rst = 1'b0;
        saw_tick = 0; saw_run = 0; saw_dir0 = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (u_if.tick) saw_tick = 1;
            if (u_if.run)  saw_run  = 1;
            if (!u_if.dir) saw_dir0 = 1;
        end
        check("idle_tick", saw_tick, 0);
        check("idle_run",  saw_run,  0);
        check("idle_dir",  saw_dir0, 0);

        // Clean run press held for 10 sampling edges
        u_if.btn_run = 1'b1;
        step(5);
        check("run_lat_early", u_if.run, 0);
        step(1);
        check("run_lat", u_if.run, 1);
        edges_to_tick(10, n);
        check("first_tick", n, 4);
        u_if.btn_run = 1'b0;
        step(1);
        check("tick_width", u_if.tick, 0);
        edges_to_tick(10, n);
        check("tick_period_a", n, 3);
        edges_to_tick(10, n);
        check("tick_period_b", n, 4);
        check("no_release_toggle", u_if.run, 1);

        // Pause so that the phase freezes at pcnt=2
        u_if.btn_run = 1'b1;
        step(3);
        check("pre_pause_notick", u_if.tick, 0);
        step(1);
        check("pre_pause_tick", u_if.tick, 1);
        step(1);
        check("pause_run_still", u_if.run, 1);
        step(1);
        check("pause_run", u_if.run, 0);
        check("pause_tick", u_if.tick, 0);
        u_if.btn_run = 1'b0;
        saw_tick = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (u_if.tick) saw_tick = 1;
        end

        // Bounce: 2-cycle pulses must never be accepted
        for (int i = 0; i < 12; i++) begin
            u_if.btn_run = ((i / 2) % 2 == 0);
            step(1);
            if (u_if.tick) saw_tick = 1;
        end
        u_if.btn_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (u_if.tick) saw_tick = 1;
        end
        check("bounce_run", u_if.run, 0);
        check("paused_notick", saw_tick, 0);
        check("paused_pcnt", dut.r_pcnt, 2);

        // Minimum 3-cycle press resumes from pcnt=2
        u_if.btn_run = 1'b1;
        step(3);
        u_if.btn_run = 1'b0;
        step(2);
        check("short_press_early", u_if.run, 0);
        step(1);
        check("short_press_run", u_if.run, 1);
        edges_to_tick(10, n);
        check("resume_tick", n, 2);
        edges_to_tick(10, n);
        check("resume_period_a", n, 4);
        edges_to_tick(10, n);
        check("resume_period_b", n, 4);
        check("single_toggle", u_if.run, 1);

        // Direction press must not disturb tick cadence
        u_if.btn_dir = 1'b1;
        step(4);
        check("dir_cad_tick", u_if.tick, 1);
        check("dir_early", u_if.dir, 1);
        step(1);
        check("dir_still", u_if.dir, 1);
        step(1);
        check("dir_toggle", u_if.dir, 0);
        u_if.btn_dir = 1'b0;
        edges_to_tick(10, n);
        check("dir_tick_a", n, 2);
        edges_to_tick(10, n);
        check("dir_tick_b", n, 4);

        // Both buttons on the same cycle toggle both on the same edge
        u_if.btn_run = 1'b1;
        u_if.btn_dir = 1'b1;
        step(5);
        check("both_run_early", u_if.run, 1);
        check("both_dir_early", u_if.dir, 0);
        step(1);
        check("both_run", u_if.run, 0);
        check("both_dir", u_if.dir, 1);
        u_if.btn_run = 1'b0;
        u_if.btn_dir = 1'b0;
        step(8);

        // Resume with dir=0, then reset at pcnt=2 while running
        u_if.btn_run = 1'b1;
        u_if.btn_dir = 1'b1;
        step(6);
        check("pre_rst_run", u_if.run, 1);
        check("pre_rst_dir", u_if.dir, 0);
        u_if.btn_run = 1'b0;
        u_if.btn_dir = 1'b0;
        edges_to_tick(10, n);
        check("pre_rst_tick", n, 2);
        step(2);
        check("pre_rst_pcnt", dut.r_pcnt, 2);
        rst = 1'b1;
        u_if.btn_run = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_tick", u_if.tick, 0);
        check("mid_rst_run",  u_if.run,  0);
        check("mid_rst_dir",  u_if.dir,  1);
        check("mid_rst_pcnt", dut.r_pcnt, 0);

        // Button held through reset release gives one press after full latency
        step(5);
        check("held_run_early", u_if.run, 0);
        step(1);
        check("held_run", u_if.run, 1);
        u_if.btn_run = 1'b0;
        edges_to_tick(10, n);
        check("post_rst_tick", n, 4);
        step(8);
        check("post_rst_run_kept", u_if.run, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
